// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Response bundle carried through the fixed-latency return pipe.
package imem_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } imem_resp_t;

  localparam int          IMEM_LAT_MAX   = 4;
  localparam logic [31:0] IMEM_ERR_RDATA = 32'h0;

endpackage

// File: rtl/imem_resp_pipe.sv
// LATENCY-stage response delay line; stage 0 captures the RAM read.
// Payload only moves with a valid bit, so the outputs hold between beats.
module imem_resp_pipe
  import imem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  imem_resp_t in_i,
  output imem_resp_t out_o
);

  logic [LATENCY-1:0] vld_d, vld_q;
  logic [LATENCY-1:0] err_d, err_q;
  logic [31:0]        dat_d [LATENCY];
  logic [31:0]        dat_q [LATENCY];

  always_comb begin
    vld_d    = {vld_q[LATENCY-1:0]} << 1;
    vld_d[0] = in_i.valid;
    err_d    = err_q;
    dat_d    = dat_q;
    if (in_i.valid) begin
      err_d[0] = in_i.err;
      dat_d[0] = in_i.rdata;
    end
    for (int i = 1; i < LATENCY; i++) begin
      if (vld_q[i-1]) begin
        err_d[i] = err_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  // Only the output stage payload is cleared so the ports read zero in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q            <= '0;
      err_q[LATENCY-1] <= 1'b0;
      dat_q[LATENCY-1] <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      dat_q <= dat_d;
    end
  end

  assign out_o.valid = vld_q[LATENCY-1];
  assign out_o.err   = err_q[LATENCY-1];
  assign out_o.rdata = dat_q[LATENCY-1];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: word RAM, address decode, grant throttle,
// outstanding counter and fixed-latency in-order return pipe.
module instr_mem_responder
  import imem_pkg::*;
#(
  parameter int          MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2,
  localparam int         AW              = $clog2(MEM_WORDS),
  localparam int         OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_req_i,
  output logic          instr_gnt_o,
  input  logic [31:0]   instr_addr_i,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  output logic          instr_rvalid_o,
  input  logic          gnt_stall_i,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [31:0]   load_data_i,
  output logic [OW-1:0] outstanding_o
);

  localparam logic [OW-1:0] MAX_C   = OW'(MAX_OUTSTANDING);
  localparam logic [29:0]   WORDS_C = 30'(MEM_WORDS);

  if (LATENCY < 1 || LATENCY > IMEM_LAT_MAX) begin : g_bad_lat
    $error("instr_mem_responder: LATENCY out of range");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY + 1) begin : g_bad_max
    $error("instr_mem_responder: MAX_OUTSTANDING out of range");
  end
  if (MEM_WORDS < 2 || MEM_WORDS > (1 << 24) ||
      (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
    $error("instr_mem_responder: MEM_WORDS must be a power of two");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("instr_mem_responder: BASE_ADDR must be word aligned");
  end

  logic [31:0]   mem [MEM_WORDS];
  logic [29:0]   idx;
  logic          dec_err;
  logic          accept;
  logic [OW-1:0] out_d, out_q;
  imem_resp_t    s0_in, rsp;

  always_comb begin
    idx     = 30'((instr_addr_i - BASE_ADDR) >> 2);
    dec_err = (instr_addr_i < BASE_ADDR) | (idx >= WORDS_C);
  end

  // A response leaving this cycle frees its slot for a same-cycle grant.
  assign instr_gnt_o = instr_req_i & ~gnt_stall_i &
                       ((out_q < MAX_C) | rsp.valid);
  assign accept      = instr_req_i & instr_gnt_o;

  always_comb begin
    s0_in.valid = accept;
    s0_in.err   = dec_err;
    s0_in.rdata = IMEM_ERR_RDATA;
    if (!dec_err) s0_in.rdata = mem[idx[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (load_we_i) mem[load_addr_i] <= load_data_i;
  end

  imem_resp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .in_i  (s0_in),
    .out_o (rsp)
  );

  always_comb out_d = out_q + OW'(accept) - OW'(rsp.valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assert property (@(posedge clk) disable iff (rst) out_d <= MAX_C);
  assert property (@(posedge clk) disable iff (rst)
                   !(rsp.valid && !accept && out_q == '0));

  assign instr_rvalid_o = rsp.valid;
  assign instr_err_o    = rsp.err;
  assign instr_rdata_o  = rsp.rdata;
  assign outstanding_o  = out_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder across three latency configs.
// Instance 0: L1 base 0, instance 1: L3 base 0x100, instance 2: L2 base 0.
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req [3];
  logic [31:0] addr;
  logic        stall;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        gnt [3];
  logic        rvalid [3];
  logic        err [3];
  logic [31:0] rdata [3];
  logic [1:0]  outst [3];

  int errs   = 0;
  int checks = 0;

  logic [31:0] w [8] = '{32'h0000_0013, 32'h00A0_0093, 32'h1111_1111,
                         32'h3333_3333, 32'h4444_4444, 32'h5555_5555,
                         32'h6666_6666, 32'h7777_7777};
  bit eg [11] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0};
  bit er [11] = '{0, 0, 0, 1, 1, 0, 1, 1, 0, 1, 1};

  always #5 clk = ~clk;

  instr_mem_responder #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2)
  ) u_a (
    .clk(clk), .rst(rst), .instr_req_i(req[0]), .instr_gnt_o(gnt[0]),
    .instr_addr_i(addr), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
    .instr_rvalid_o(rvalid[0]), .gnt_stall_i(stall),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
    .outstanding_o(outst[0])
  );

  instr_mem_responder #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h100), .LATENCY(3), .MAX_OUTSTANDING(2)
  ) u_b (
    .clk(clk), .rst(rst), .instr_req_i(req[1]), .instr_gnt_o(gnt[1]),
    .instr_addr_i(addr), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
    .instr_rvalid_o(rvalid[1]), .gnt_stall_i(stall),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
    .outstanding_o(outst[1])
  );

  instr_mem_responder #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2), .MAX_OUTSTANDING(2)
  ) u_c (
    .clk(clk), .rst(rst), .instr_req_i(req[2]), .instr_gnt_o(gnt[2]),
    .instr_addr_i(addr), .instr_rdata_o(rdata[2]), .instr_err_o(err[2]),
    .instr_rvalid_o(rvalid[2]), .gnt_stall_i(stall),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
    .outstanding_o(outst[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic one_read(input int s, input logic [31:0] a, input int lat,
                          input logic e_err, input logic [31:0] e_dat,
                          input bit ld, input logic [9:0] la,
                          input logic [31:0] ldd, input string tag);
    @(negedge clk);
    addr   = a;
    req[s] = 1'b1;
    if (ld) begin
      load_we   = 1'b1;
      load_addr = la;
      load_data = ldd;
    end
    #1 chk({tag, "_gnt"}, 32'(gnt[s]), 32'd1);
    @(posedge clk);
    #1;
    req[s]  = 1'b0;
    load_we = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk({tag, "_rv"}, 32'(rvalid[s]), 32'(i == lat));
      if (i == lat) begin
        chk({tag, "_err"}, 32'(err[s]), 32'(e_err));
        chk({tag, "_data"}, rdata[s], e_dat);
      end
    end
  endtask

  initial begin
    int g;
    int d;
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    addr = '0; stall = 1'b0;
    load_we = 1'b0; load_addr = '0; load_data = '0;

    #1 rst = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rvalid", 32'(rvalid[k]), 32'd0);
      chk("rst_err", 32'(err[k]), 32'd0);
      chk("rst_rdata", rdata[k], 32'd0);
      chk("rst_outst", 32'(outst[k]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      load_we = 1'b1; load_addr = 10'(k); load_data = w[k];
    end
    @(negedge clk);
    load_addr = 10'd1023; load_data = 32'hCAFE_F00D;
    @(negedge clk);
    load_we = 1'b0;

    // back-to-back on the single-cycle instance
    @(negedge clk);
    addr = 32'h0; req[0] = 1'b1;
    #1 chk("t1_gnt0", 32'(gnt[0]), 32'd1);
    @(negedge clk);
    addr = 32'h4;
    #1 chk("t1_gnt1", 32'(gnt[0]), 32'd1);
    chk("t1_rv0", 32'(rvalid[0]), 32'd1);
    chk("t1_d0", rdata[0], 32'h0000_0013);
    @(negedge clk);
    req[0] = 1'b0;
    #1 chk("t1_rv1", 32'(rvalid[0]), 32'd1);
    chk("t1_d1", rdata[0], 32'h00A0_0093);
    chk("t1_err", 32'(err[0]), 32'd0);
    @(negedge clk);
    chk("t1_idle", 32'(rvalid[0]), 32'd0);
    chk("t1_out", 32'(outst[0]), 32'd0);

    // continuous request against the outstanding cap
    g = 0; d = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      req[1] = (c < 8);
      addr   = 32'h100 + 32'(4 * g);
      #1 chk("t2_gnt", 32'(gnt[1]), 32'(eg[c]));
      chk("t2_rv", 32'(rvalid[1]), 32'(er[c]));
      if (er[c]) begin
        chk("t2_data", rdata[1], w[d]);
        d++;
      end
      chk("t2_out_le2", 32'(outst[1] <= 2'd2), 32'd1);
      if (eg[c]) g++;
    end
    @(negedge clk);
    chk("t2_drain", 32'(outst[1]), 32'd0);

    one_read(0, 32'h2, 1, 1'b0, w[0], 1'b0, '0, '0, "t3_lo2");
    one_read(0, 32'h6, 1, 1'b0, w[1], 1'b0, '0, '0, "t3_lo6");
    one_read(1, 32'h0FC, 3, 1'b1, 32'h0, 1'b0, '0, '0, "t3_below");
    one_read(1, 32'h1100, 3, 1'b1, 32'h0, 1'b0, '0, '0, "t3_above");
    one_read(1, 32'h10FC, 3, 1'b0, 32'hCAFE_F00D, 1'b0, '0, '0, "t3_top");

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      stall = 1'b1; req[1] = 1'b1; addr = 32'h104;
      #1 chk("t4_stall_gnt", 32'(gnt[1]), 32'd0);
      chk("t4_stall_rv", 32'(rvalid[1]), 32'd0);
    end
    stall = 1'b0; req[1] = 1'b0;
    one_read(1, 32'h104, 3, 1'b0, w[1], 1'b0, '0, '0, "t4_rel");

    one_read(2, 32'h8, 2, 1'b0, w[2], 1'b1, 10'd2, 32'hDEAD_BEEF, "t5_rbw");
    one_read(2, 32'h8, 2, 1'b0, 32'hDEAD_BEEF, 1'b0, '0, '0, "t5_new");

    // reset with two requests in flight
    @(negedge clk);
    addr = 32'h100; req[1] = 1'b1;
    #1 chk("t6_gnt0", 32'(gnt[1]), 32'd1);
    @(negedge clk);
    addr = 32'h104;
    #1 chk("t6_gnt1", 32'(gnt[1]), 32'd1);
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(negedge clk);
    chk("t6_inflight", 32'(outst[1]), 32'd2);
    rst = 1'b1;
    #1 chk("t6_rst_out", 32'(outst[1]), 32'd0);
    chk("t6_rst_rdata", rdata[1], 32'd0);
    chk("t6_rst_err", 32'(err[1]), 32'd0);
    chk("t6_rst_rv", 32'(rvalid[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t6_no_rv", 32'(rvalid[1]), 32'd0);
      chk("t6_out0", 32'(outst[1]), 32'd0);
    end
    one_read(1, 32'h10C, 3, 1'b0, w[3], 1'b0, '0, '0, "t6_post");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
